// File: rtl/button_pkg.sv
// Shared definitions for the button press generator: FSM state encodings
// and small elaboration-time width helpers.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Bits needed to hold values 0..v-1 (never less than 1).
    function automatic int clog2w(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/button_gen_timer.sv
// Loadable down-counter shared by the PRESS and GAP phases.
// A load wins over enable; the count holds once it reaches zero.
module button_gen_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, decrement while enabled and non-zero, else hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/button_press_gen.sv
// Button press generator: turns one-cycle press requests into timed
// press (high) / gap (low) waveforms, queuing requests that arrive while
// a waveform is in progress.
// Optional macro BUTTON_PRESS_GEN_BOUNCE_EN: emulate contact bounce
// (1,0,1,0,...) at the start of each press.
module button_press_gen
    import button_pkg::*;
#(
    parameter int PRESS_CYCLES  = 1000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int MAX_PENDING   = 4,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req,
    output logic                               button_out,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int TW = clog2w(max2(PRESS_CYCLES, GAP_CYCLES) + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] MAX_PEND_W = PW'(MAX_PENDING);

    state_t        state_q, state_d;
    logic          button_out_q, button_out_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_en;
    logic [TW-1:0] tmr_count;
    logic          tmr_zero;
    logic          consume;
    logic          enqueue;

    button_gen_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // FSM next state and timer control; a press started from GAP consumes
    // one queued request (or the coincident req).
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        consume      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d      = ST_PRESS;
                    tmr_load     = 1'b1;
                    tmr_load_val = PRESS_LOAD;
                end
            end
            ST_PRESS: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d      = ST_GAP;
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LOAD;
                end
            end
            ST_GAP: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    if ((pending_q != '0) || req) begin
                        state_d      = ST_PRESS;
                        tmr_load     = 1'b1;
                        tmr_load_val = PRESS_LOAD;
                        consume      = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue counter: enqueue on any req outside IDLE; simultaneous enqueue
    // and consume cancel; a full queue drops the request and flags overflow.
    always_comb begin
        enqueue    = req && (state_q != ST_IDLE);
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (enqueue && !consume) begin
            if (pending_q == MAX_PEND_W) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!enqueue && consume) begin
            pending_d = pending_q - 1'b1;
        end
    end

`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
    localparam int          BOUNCE_LEN = min2(BOUNCE_CYCLES, PRESS_CYCLES - 1);
    localparam logic [TW:0] PRESS_W    = (TW + 1)'(PRESS_CYCLES);
    localparam logic [TW:0] BOUNCE_W   = (TW + 1)'(BOUNCE_LEN);

    logic [TW:0] press_idx;

    // Button level for the next cycle: index into the press derived from the
    // timer; even indices high, odd low, until the bounce window ends.
    always_comb begin
        press_idx    = PRESS_W - {1'b0, tmr_count};
        button_out_d = 1'b0;
        if (state_d == ST_PRESS) begin
            if (state_q != ST_PRESS) begin
                button_out_d = 1'b1;
            end else if (press_idx < BOUNCE_W) begin
                button_out_d = ~press_idx[0];
            end else begin
                button_out_d = 1'b1;
            end
        end
    end
`else
    // Button level for the next cycle: high throughout PRESS.
    always_comb begin
        button_out_d = (state_d == ST_PRESS);
    end
`endif

    // State, button and queue registers; reset aborts any waveform at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            button_out_q <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            button_out_q <= button_out_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign button_out = button_out_q;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE) || (pending_q != '0);
    assign done       = (state_q == ST_GAP) && tmr_zero;

endmodule

// File: tb/tb_button_press_gen.sv
// Directed bench for button_press_gen with an in-bench model based on
// "cycles since the current press began" and a request count.
module tb_button_press_gen;

    localparam int P  = 4;
    localparam int G  = 3;
    localparam int MP = 2;
    localparam int BC = 3;
    localparam int PW = $clog2(MP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          button_out;
    logic          busy;
    logic          done;
    logic [PW-1:0] pending;
    logic          overflow;

    button_press_gen #(
        .PRESS_CYCLES  (P),
        .GAP_CYCLES    (G),
        .MAX_PENDING   (MP),
        .BOUNCE_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .button_out (button_out),
        .busy       (busy),
        .done       (done),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: whether a press/gap waveform is running, cycles into it, queue.
    bit m_active;
    int m_t;
    int m_pend;
    bit m_ovf;

    // Per-test observations (cycle c = period following edge c-1).
    int cyc;
    int rise_q[$];
    int hi_cnt;
    int done_cnt;
    int first_done;
    int busy_low;
    int max_pend;
    logic prev_btn;

    function automatic logic exp_button();
        int bb;
        if (!m_active || m_t >= P) return 1'b0;
        bb = (BC < P - 1) ? BC : P - 1;
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
        if (m_t < bb) return (m_t % 2) == 0;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc + 1, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_pend   = 0;
        m_ovf    = 0;
    endtask

    // Advance the model by one clock edge with request r sampled.
    task automatic model_edge(input bit r);
        int avail;
        if (!m_active) begin
            if (r) begin
                m_active = 1;
                m_t      = 0;
            end
        end else if (m_t == P + G - 1) begin
            avail = m_pend + (r ? 1 : 0);
            if (avail > 0) begin
                m_t    = 0;
                m_pend = avail - 1;
            end else begin
                m_active = 0;
            end
        end else begin
            m_t++;
            if (r) begin
                if (m_pend < MP) m_pend++;
                else m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("button_out", 32'(button_out), 32'(exp_button()));
        check("done", 32'(done), 32'(m_active && (m_t == P + G - 1)));
        check("busy", 32'(busy), 32'(m_active || (m_pend > 0)));
        check("pending", 32'(pending), 32'(m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic clear_obs();
        cyc        = 0;
        rise_q     = {};
        hi_cnt     = 0;
        done_cnt   = 0;
        first_done = -1;
        busy_low   = -1;
        max_pend   = 0;
        prev_btn   = 1'b0;
    endtask

    // One clock: drive req, let the edge happen, compare on the falling edge.
    task automatic step(input bit r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        compare_all();
        if (button_out && !prev_btn) rise_q.push_back(cyc + 1);
        if (button_out) hi_cnt++;
        if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = cyc + 1;
        end
        if (!busy && busy_low < 0 && rise_q.size() > 0) busy_low = cyc + 1;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        prev_btn = button_out;
        cyc++;
    endtask

    task automatic run(input logic [63:0] mask, input int n);
        for (int k = 0; k < n; k++) step(mask[k]);
    endtask

    task automatic do_reset();
        req   = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_button", 32'(button_out), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        clear_obs();
    endtask

    initial begin
        logic [63:0] m;

        // Single request at cycle 10.
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        m = 64'h1 << 10;
        run(m, 22);
        check("t1_first_rise", 32'(rise_q[0]), 32'd11);
        check("t1_first_done", 32'(first_done), 32'd17);
        check("t1_busy_low", 32'(busy_low), 32'd18);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
`ifdef BUTTON_PRESS_GEN_BOUNCE_EN
        check("t1_events", 32'(rise_q.size()), 32'd2);
        check("t1_hi_cycles", 32'(hi_cnt), 32'd3);
`else
        check("t1_events", 32'(rise_q.size()), 32'd1);
        check("t1_hi_cycles", 32'(hi_cnt), 32'd4);
`endif

        // Requests at 10, 11, 12: back-to-back presses from the queue.
        do_reset();
        m = (64'h1 << 10) | (64'h1 << 11) | (64'h1 << 12);
        run(m, 36);
        check("t2_done_cnt", 32'(done_cnt), 32'd3);
        check("t2_max_pend", 32'(max_pend), 32'd2);
        check("t2_overflow", 32'(overflow), 32'd0);
`ifndef BUTTON_PRESS_GEN_BOUNCE_EN
        check("t2_rises", 32'(rise_q.size()), 32'd3);
        check("t2_rise0", 32'(rise_q[0]), 32'd11);
        check("t2_rise1", 32'(rise_q[1]), 32'd18);
        check("t2_rise2", 32'(rise_q[2]), 32'd25);
`endif

        // Requests at 10..13: fourth dropped, overflow sticks.
        do_reset();
        m = (64'h1 << 10) | (64'h1 << 11) | (64'h1 << 12) | (64'h1 << 13);
        run(m, 40);
        check("t3_done_cnt", 32'(done_cnt), 32'd3);
        check("t3_overflow", 32'(overflow), 32'd1);
`ifndef BUTTON_PRESS_GEN_BOUNCE_EN
        check("t3_hi_cycles", 32'(hi_cnt), 32'd12);
`endif

        // Request coincident with the final GAP cycle, queue empty.
        do_reset();
        m = (64'h1 << 10) | (64'h1 << 17);
        run(m, 30);
        check("t4_done_cnt", 32'(done_cnt), 32'd2);
        check("t4_max_pend", 32'(max_pend), 32'd0);
`ifndef BUTTON_PRESS_GEN_BOUNCE_EN
        check("t4_rise1", 32'(rise_q[1]), 32'd18);
`endif

        // Asynchronous reset mid-press with a full queue and overflow set.
        do_reset();
        m = (64'h1 << 10) | (64'h1 << 11) | (64'h1 << 12) | (64'h1 << 13);
        run(m, 14);
        check("t5_pre_pending", 32'(pending), 32'd2);
        check("t5_pre_overflow", 32'(overflow), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_async_button", 32'(button_out), 32'd0);
        check("t5_async_pending", 32'(pending), 32'd0);
        check("t5_async_overflow", 32'(overflow), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        clear_obs();
        m = 64'h1 << 2;
        run(m, 14);
        check("t5_done_cnt", 32'(done_cnt), 32'd1);
        check("t5_first_rise", 32'(rise_q[0]), 32'd3);
`ifndef BUTTON_PRESS_GEN_BOUNCE_EN
        check("t5_hi_cycles", 32'(hi_cnt), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_press_gen.md
Name: button_press_gen

Overview:
- Transmit-side counterpart of the push/release detector: turns one-cycle press requests into clean, timed button waveforms (press high, then release low).
- Drives the detector's `button` input through the board-level self-test mux. The password FSM can then be exercised without a human on the Basys 3.
- Queues requests that arrive while a waveform is in progress.

Parameters:
- PRESS_CYCLES, 1000000, cycles button_out is held high per press (≥1; 10 ms at 100 MHz).
- GAP_CYCLES, 1000000, cycles button_out is held low after each press before the next press may start (≥1).
- MAX_PENDING, 4, depth of the request queue counter (≥1).
- BOUNCE_CYCLES, 8, length of emulated contact bounce; used only with the optional feature (≥0).

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- req  input  1  one-cycle press request
- button_out  output  1  generated button level, registered
- busy  output  1  high while state≠IDLE or pending≠0
- done  output  1  one-cycle pulse in the final GAP cycle of each press
- pending  output  $clog2(MAX_PENDING+1)  queued requests not yet started
- overflow  output  1  sticky; a request was dropped because the queue was full

Behaviour:
- Reset values: state=IDLE, button_out=0, done=0, pending=0, overflow=0, timer=0. Async reset mid-waveform aborts immediately: button_out drops to 0 and queued requests are lost.
- States: IDLE, PRESS, GAP.
- Timer width: $clog2(max(PRESS_CYCLES,GAP_CYCLES)+1).
- IDLE:
  - If req=1 is sampled at edge N, go to PRESS at N+1, load timer=PRESS_CYCLES-1, and set button_out=1 from N+1.
  - pending is always 0 in IDLE.
- PRESS:
  - button_out=1; timer decrements each cycle.
  - At timer=0, go to GAP and load GAP_CYCLES-1.
  - button_out is high for exactly PRESS_CYCLES cycles.
- GAP:
  - button_out=0 for exactly GAP_CYCLES cycles; done=1 during the last one (timer=0).
  - At the end of GAP, if pending>0 or req=1, go straight to PRESS; otherwise go to IDLE.
- Queue:
  - A req arriving while state≠IDLE increments pending.
  - Starting a press from GAP consumes one: pending decrements, or req is used directly when pending=0.
  - Simultaneous enqueue and consume leaves pending unchanged.
  - A req when pending=MAX_PENDING and no consume this cycle is dropped and overflow←1. overflow clears only on reset.
- req held high for several cycles counts as several requests; the source must pulse.
- Back-to-back presses with the queue non-empty: one press every PRESS_CYCLES+GAP_CYCLES cycles, no idle cycle between them.
- busy is combinational from registered state and pending.

Optional Feature:
- Macro: BUTTON_PRESS_GEN_BOUNCE_EN.
- Defined:
  - During the first B=min(BOUNCE_CYCLES, PRESS_CYCLES-1) cycles of PRESS, button_out toggles every cycle starting at 1 (1,0,1,0,…).
  - It is then steady high for the remaining cycles.
  - The PRESS length and all other timing are unchanged.
  - Purpose: stresses the un-debounced detector, which reports multiple events.
- Undefined: clean waveforms only. BOUNCE_CYCLES is unused and the bounce logic is absent.

Decomposition:
- Shared package button_pkg:
  - state encodings for IDLE/PRESS/GAP (2-bit, same style as the detector's encodings);
  - a clog2-style width helper function.
- One natural sub-module, button_gen_timer: a loadable down-counter with load value, enable and a zero flag. Instantiated once and reused for the PRESS and GAP phases.
- The queue counter and FSM stay in the top module.

Test Plan (PRESS_CYCLES=4, GAP_CYCLES=3, MAX_PENDING=2, BOUNCE_CYCLES=3, detector instance attached to button_out):
- Single req at cycle 10:
  - button_out high cycles 11–14, low 15–17; done=1 at cycle 17; busy low from cycle 18.
  - The detector emits exactly one button_pushed pulse.
- Reqs at cycles 10, 11, 12:
  - pending goes 1 then 2.
  - Presses start at 11, 18 and 25 with no idle gap between them; three done pulses; overflow=0.
- Reqs at cycles 10, 11, 12, 13 with MAX_PENDING=2: fourth req dropped, overflow=1 and stays 1, only three presses generated.
- req coincident with the final GAP cycle and pending=0: next PRESS starts the following cycle and pending stays 0.
- Reset asserted at cycle 13 mid-PRESS:
  - button_out=0, pending=0, overflow=0 immediately (asynchronously).
  - After release, a new req produces a normal 4-cycle press.
- With BUTTON_PRESS_GEN_BOUNCE_EN, single req at cycle 10:
  - button_out = 1,0,1,1 over cycles 11–14.
  - The detector reports 2 events; without the macro it reports 1.
